// File: rtl/ro_puf_pkg.sv
// Shared constants for the ring-oscillator PUF: FSM encoding and default sizing
// used by both the pair counter and the array controller.
package ro_puf_pkg;

  localparam int unsigned DefWindow     = 1024;
  localparam int unsigned DefSettle     = 4;
  localparam int unsigned DefCntW       = 16;
  localparam int unsigned DefSyncStages = 2;

  localparam logic [2:0] StIdle    = 3'd0;
  localparam logic [2:0] StSettle  = 3'd1;
  localparam logic [2:0] StCount   = 3'd2;
  localparam logic [2:0] StCompare = 3'd3;
  localparam logic [2:0] StDone    = 3'd4;

endpackage

// File: rtl/ro_edge_sync.sv
// Synchronizes an asynchronous oscillator output into clk and flags its rising edges.
module ro_edge_sync
  import ro_puf_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = DefSyncStages
) (
  input  logic clk,
  input  logic rst,
  input  logic async_in,
  output logic edge_pulse
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], async_in};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign edge_pulse = sync_q[SYNC_STAGES-1] & ~prev_q;

endmodule

// File: rtl/ro_pair_counter.sv
// Enables a ring-oscillator pair, counts edges of each over a fixed window and
// emits a single comparison response bit.
module ro_pair_counter
  import ro_puf_pkg::*;
#(
  parameter int unsigned WINDOW      = DefWindow,
  parameter int unsigned SETTLE      = DefSettle,
  parameter int unsigned CNT_W       = DefCntW,
  parameter int unsigned SYNC_STAGES = DefSyncStages
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             ro_a,
  input  logic             ro_b,
  output logic             ro_en,
  output logic             busy,
  output logic             done,
  output logic             response,
  output logic             tie,
  output logic [CNT_W-1:0] cnt_a,
  output logic [CNT_W-1:0] cnt_b
);

  localparam int unsigned WcW = $clog2(WINDOW + SETTLE + 1);

  logic [2:0]       state_q, state_d;
  logic [WcW-1:0]   wcnt_q, wcnt_d;
  logic [CNT_W-1:0] cnt_a_q, cnt_b_q;
  logic             response_q, tie_q;
  logic             edge_a, edge_b;

  ro_edge_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync_a (
    .clk       (clk),
    .rst       (rst),
    .async_in  (ro_a),
    .edge_pulse(edge_a)
  );

  ro_edge_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync_b (
    .clk       (clk),
    .rst       (rst),
    .async_in  (ro_b),
    .edge_pulse(edge_b)
  );

  // Window counter is loaded with (phase length - 1) and counts down to zero.
  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StSettle;
          wcnt_d  = WcW'(SETTLE - 1);
        end
      end
      StSettle: begin
        if (wcnt_q == '0) begin
          state_d = StCount;
          wcnt_d  = WcW'(WINDOW - 1);
        end else begin
          wcnt_d = wcnt_q - WcW'(1);
        end
      end
      StCount: begin
        if (wcnt_q == '0) begin
          state_d = StCompare;
        end else begin
          wcnt_d = wcnt_q - WcW'(1);
        end
      end
      StCompare: state_d = StDone;
      StDone:    state_d = StIdle;
      default:   state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= StIdle;
      wcnt_q     <= '0;
      cnt_a_q    <= '0;
      cnt_b_q    <= '0;
      response_q <= 1'b0;
      tie_q      <= 1'b0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
      if (state_q == StIdle && start) begin
        cnt_a_q    <= '0;
        cnt_b_q    <= '0;
        response_q <= 1'b0;
        tie_q      <= 1'b0;
      end
      if (state_q == StCount) begin
        if (edge_a && cnt_a_q != '1) cnt_a_q <= cnt_a_q + CNT_W'(1);
        if (edge_b && cnt_b_q != '1) cnt_b_q <= cnt_b_q + CNT_W'(1);
      end
      if (state_q == StCompare) begin
        response_q <= cnt_a_q > cnt_b_q;
        tie_q      <= cnt_a_q == cnt_b_q;
      end
    end
  end

  assign ro_en    = (state_q == StSettle) || (state_q == StCount);
  assign busy     = ro_en || (state_q == StCompare);
  assign done     = state_q == StDone;
  assign response = response_q;
  assign tie      = tie_q;
  assign cnt_a    = cnt_a_q;
  assign cnt_b    = cnt_b_q;

endmodule
